// File: rtl/text_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | text_loader_pkg : shared state encodings and constants for the text loader |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package text_loader_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_LOAD = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;
    localparam logic [STATE_W-1:0] ST_ERR  = 2'd3;

    // RISC-V "addi x0, x0, 0"
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/text_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | text_ram : instruction store, one synchronous write port, one async read   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module text_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Power-up contents are zero; reset never touches the array.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/text_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | text_loader : assembles a little-endian byte stream into instruction words |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module text_loader
    import text_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  load_end,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [STATE_W-1:0]    state;
    logic [STATE_W-1:0]    next_state;
    logic [1:0]            lane;
    logic [1:0]            lane_after;
    logic [31:0]           asm_buf;
    logic                  pad_pend;
    logic                  accept;
    logic                  full;
    logic                  word_wr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_LOAD: begin
                if (pad_pend) begin
                    next_state = ST_DONE;
                end else if (accept && full) begin
                    next_state = ST_ERR;
                end else if (load_end && (lane_after == 2'd0)) begin
                    next_state = ST_DONE;
                end
            end
            default: begin
                if (load_start) begin
                    next_state = ST_LOAD;
                end
            end
        endcase
    end

    // pad_pend marks the extra cycle that flushes a partial word.
    always_comb begin
        byte_ready = (state == ST_LOAD) && !pad_pend;
        cpu_hold   = (state == ST_LOAD);
        load_done  = (state == ST_DONE);
        load_err   = (state == ST_ERR);
    end

    assign accept     = byte_valid && byte_ready;
    assign full       = (word_count == FULL_COUNT);
    assign lane_after = accept ? lane + 2'd1 : lane;
    assign word_wr    = accept && !full && (lane == 2'd3);
    assign we         = word_wr || pad_pend;
    assign wdata      = pad_pend ? DATA_WIDTH'(asm_buf)
                                 : DATA_WIDTH'({byte_data, asm_buf[23:0]});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane       <= '0;
            word_count <= '0;
            asm_buf    <= '0;
            pad_pend   <= 1'b0;
        end else if (state != ST_LOAD) begin
            if (load_start) begin
                lane       <= '0;
                word_count <= '0;
                asm_buf    <= '0;
                pad_pend   <= 1'b0;
            end
        end else if (pad_pend) begin
            pad_pend   <= 1'b0;
            word_count <= word_count + 1'b1;
            asm_buf    <= '0;
            lane       <= '0;
        end else begin
            if (accept && !full) begin
                lane <= lane + 2'd1;
                if (lane == 2'd3) begin
                    word_count <= word_count + 1'b1;
                    asm_buf    <= '0;
                end else begin
                    asm_buf[{lane, 3'b000} +: 8] <= byte_data;
                end
            end
            if (load_end && !(accept && full) && (lane_after != 2'd0)) begin
                pad_pend <= 1'b1;
            end
        end
    end

    text_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_text_ram (
        .clk   (clk),
        .we    (we),
        .waddr (word_count[ADDR_WIDTH-1:0]),
        .wdata (wdata),
        .raddr (read_addr),
        .rdata (data)
    );

endmodule
`default_nettype wire

// File: tb/tb_text_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_text_loader : randomized self-checking bench with a word-packing model  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_text_loader;
    import text_loader_pkg::*;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int SAW = 2;

    logic          clk;
    logic          rst;
    logic          load_start, load_end, byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] data;
    logic          cpu_hold, load_done, load_err;
    logic [AW:0]   word_count;

    logic           s_load_start, s_load_end, s_byte_valid;
    logic [7:0]     s_byte_data;
    logic           s_byte_ready;
    logic [SAW-1:0] s_read_addr;
    logic [DW-1:0]  s_data;
    logic           s_cpu_hold, s_load_done, s_load_err;
    logic [SAW:0]   s_word_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mm [1024];
    logic [31:0] sm [4];

    text_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_end(load_end),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .read_addr(read_addr), .data(data), .cpu_hold(cpu_hold),
        .load_done(load_done), .load_err(load_err), .word_count(word_count)
    );

    text_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(SAW)) dut_small (
        .clk(clk), .rst(rst), .load_start(s_load_start), .load_end(s_load_end),
        .byte_valid(s_byte_valid), .byte_data(s_byte_data), .byte_ready(s_byte_ready),
        .read_addr(s_read_addr), .data(s_data), .cpu_hold(s_cpu_hold),
        .load_done(s_load_done), .load_err(s_load_err), .word_count(s_word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_session;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
    endtask

    // Packs a byte list into little-endian words; a complete session zero-pads the tail.
    task automatic model_session(input logic [7:0] q[$], input bit complete, output int nw);
        int n;
        logic [31:0] v;
        n  = q.size();
        nw = complete ? (n + 3) / 4 : n / 4;
        for (int w = 0; w < nw; w++) begin
            v = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (w * 4 + k < n) v[8*k +: 8] = q[w*4 + k];
            end
            mm[w] = v;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        load_start = 0; load_end = 0; byte_valid = 0; byte_data = 0; read_addr = 0;
        s_load_start = 0; s_load_end = 0; s_byte_valid = 0; s_byte_data = 0; s_read_addr = 0;
        for (int i = 0; i < 1024; i++) mm[i] = 32'h0;
        for (int i = 0; i < 4; i++) sm[i] = 32'h0;
        repeat (2) tick();
        checks++;
        if ({byte_ready, cpu_hold, load_done, load_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got %b exp 0000", {byte_ready, cpu_hold, load_done, load_err});
        end
        checks++;
        if (word_count !== '0) begin
            failures++;
            $display("FAIL reset_word_count got %0d exp 0", word_count);
        end
        rst = 1'b0;
        tick();
        for (int a = 0; a < 4; a++) begin
            read_addr = AW'(a);
            #1;
            checks++;
            if (data !== 32'h0) begin
                failures++;
                $display("FAIL reset_mem[%0d] got %h exp 00000000", a, data);
            end
        end
    endtask

    task automatic test_vectors;
        logic [7:0] bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        start_session();
        for (int i = 0; i < 8; i++) send(bytes[i], 0);
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        checks++;
        if (load_done !== 1'b1 || word_count !== 11'd2 || cpu_hold !== 1'b0) begin
            failures++;
            $display("FAIL vec_status got done=%b wc=%0d hold=%b exp 1 2 0", load_done, word_count, cpu_hold);
        end
        read_addr = 0; #1;
        checks++;
        if (data !== NOP_WORD) begin
            failures++;
            $display("FAIL vec_mem0 got %h exp %h", data, NOP_WORD);
        end
        read_addr = 1; #1;
        checks++;
        if (data !== 32'h00100093) begin
            failures++;
            $display("FAIL vec_mem1 got %h exp 00100093", data);
        end
        mm[0] = NOP_WORD;
        mm[1] = 32'h00100093;
    endtask

    task automatic test_pad;
        start_session();
        send(8'hAA, 0);
        send(8'hBB, 0);
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        checks++;
        if (cpu_hold !== 1'b1 || byte_ready !== 1'b0 || load_done !== 1'b0) begin
            failures++;
            $display("FAIL pad_cycle got hold=%b ready=%b done=%b exp 1 0 0", cpu_hold, byte_ready, load_done);
        end
        tick();
        checks++;
        if (cpu_hold !== 1'b0 || load_done !== 1'b1 || word_count !== 11'd1) begin
            failures++;
            $display("FAIL pad_after got hold=%b done=%b wc=%0d exp 0 1 1", cpu_hold, load_done, word_count);
        end
        read_addr = 0; #1;
        checks++;
        if (data !== 32'h0000BBAA) begin
            failures++;
            $display("FAIL pad_mem0 got %h exp 0000bbaa", data);
        end
        mm[0] = 32'h0000BBAA;
    endtask

    task automatic test_same_cycle;
        start_session();
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 0);
        byte_valid = 1'b1; byte_data = 8'h44; load_end = 1'b1;
        tick();
        byte_valid = 1'b0; load_end = 1'b0;
        checks++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 11'd1) begin
            failures++;
            $display("FAIL same_cycle_status got done=%b hold=%b wc=%0d exp 1 0 1", load_done, cpu_hold, word_count);
        end
        read_addr = 0; #1;
        checks++;
        if (data !== 32'h44332211) begin
            failures++;
            $display("FAIL same_cycle_mem0 got %h exp 44332211", data);
        end
        mm[0] = 32'h44332211;
    endtask

    task automatic test_random;
        logic [7:0] q[$];
        int n, nw;
        bit merge;
        for (int s = 0; s < 5; s++) begin
            q = {};
            n = $urandom_range(0, 30);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            merge = (n > 0) && ($urandom_range(0, 1) == 1);
            start_session();
            for (int i = 0; i < n; i++) begin
                if (merge && i == n - 1) begin
                    repeat ($urandom_range(0, 2)) tick();
                    byte_valid = 1'b1; byte_data = q[i];
                end else begin
                    send(q[i], $urandom_range(0, 2));
                end
            end
            load_end = 1'b1;
            tick();
            load_end = 1'b0; byte_valid = 1'b0;
            if (n % 4 != 0) tick();
            model_session(q, 1'b1, nw);
            checks++;
            if (load_done !== 1'b1 || word_count !== 11'(nw)) begin
                failures++;
                $display("FAIL rand%0d_status got done=%b wc=%0d exp 1 %0d", s, load_done, word_count, nw);
            end
            for (int a = 0; a < nw + 2; a++) begin
                read_addr = AW'(a); #1;
                checks++;
                if (data !== mm[a]) begin
                    failures++;
                    $display("FAIL rand%0d_mem[%0d] got %h exp %h", s, a, data, mm[a]);
                end
            end
        end
    endtask

    task automatic test_ignored;
        logic [7:0] q[$];
        int nw;
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        checks++;
        if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
            failures++;
            $display("FAIL end_outside_load got done=%b hold=%b exp 1 0", load_done, cpu_hold);
        end
        q = {};
        for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
        start_session();
        for (int i = 0; i < 5; i++) send(q[i], 0);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 5; i < 8; i++) send(q[i], 0);
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        model_session(q, 1'b1, nw);
        checks++;
        if (word_count !== 11'd2 || load_done !== 1'b1) begin
            failures++;
            $display("FAIL start_in_load got wc=%0d done=%b exp 2 1", word_count, load_done);
        end
        read_addr = 1; #1;
        checks++;
        if (data !== mm[1]) begin
            failures++;
            $display("FAIL start_in_load_mem1 got %h exp %h", data, mm[1]);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] q[$];
        logic [31:0] old0;
        int nw;
        q = {};
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        old0 = mm[0];
        start_session();
        for (int i = 0; i < 3; i++) send(q[i], 0);
        byte_valid = 1'b1; byte_data = q[3]; read_addr = 0;
        #1;
        checks++;
        if (data !== old0) begin
            failures++;
            $display("FAIL read_during_write got %h exp old %h", data, old0);
        end
        tick();
        byte_valid = 1'b0;
        send(q[4], 0);
        send(q[5], 0);
        model_session(q, 1'b0, nw);
        for (int a = 0; a < 3; a++) begin
            read_addr = AW'(a); #1;
            checks++;
            if (data !== mm[a]) begin
                failures++;
                $display("FAIL load_sweep[%0d] got %h exp %h", a, data, mm[a]);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({byte_ready, cpu_hold, load_done, load_err} !== 4'b0000 || word_count !== '0) begin
            failures++;
            $display("FAIL async_reset got flags=%b wc=%0d exp 0000 0",
                     {byte_ready, cpu_hold, load_done, load_err}, word_count);
        end
        tick();
        rst = 1'b0;
        tick();
        for (int a = 0; a < 2; a++) begin
            read_addr = AW'(a); #1;
            checks++;
            if (data !== mm[a]) begin
                failures++;
                $display("FAIL reset_retain[%0d] got %h exp %h", a, data, mm[a]);
            end
        end
    endtask

    task automatic test_overflow;
        logic [7:0] q[$];
        logic [31:0] v;
        q = {};
        for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
        s_load_start = 1'b1;
        tick();
        s_load_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_byte_valid = 1'b1; s_byte_data = q[i];
            tick();
            s_byte_valid = 1'b0;
            if (i == 15) begin
                checks++;
                if (s_word_count !== 3'd4 || s_load_err !== 1'b0 || s_byte_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL ovf_full got wc=%0d err=%b ready=%b exp 4 0 1", s_word_count, s_load_err, s_byte_ready);
                end
            end
            if (i == 16 || i == 19) begin
                checks++;
                if (s_word_count !== 3'd4 || s_load_err !== 1'b1 || s_byte_ready !== 1'b0 || s_cpu_hold !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_err_%0d got wc=%0d err=%b ready=%b hold=%b exp 4 1 0 0",
                             i, s_word_count, s_load_err, s_byte_ready, s_cpu_hold);
                end
            end
        end
        for (int w = 0; w < 4; w++) begin
            v = {q[w*4+3], q[w*4+2], q[w*4+1], q[w*4]};
            sm[w] = v;
            s_read_addr = SAW'(w); #1;
            checks++;
            if (s_data !== sm[w]) begin
                failures++;
                $display("FAIL ovf_mem[%0d] got %h exp %h", w, s_data, sm[w]);
            end
        end
        s_load_start = 1'b1;
        tick();
        s_load_start = 1'b0;
        checks++;
        if (s_load_err !== 1'b0 || s_word_count !== '0 || s_byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL ovf_restart got err=%b wc=%0d ready=%b exp 0 0 1", s_load_err, s_word_count, s_byte_ready);
        end
        s_load_end = 1'b1;
        tick();
        s_load_end = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_pad();
        test_same_cycle();
        test_random();
        test_ignored();
        test_reset_mid();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
